// File: rtl/wb_pkg.sv
// Shared Wishbone B4 definitions for the sd_emu bus fabric.
//   WB_AW / WB_DW / WB_SW : address, data and byte-select widths.
//   CTI_* / BTE_*         : cycle-type and burst-type encodings.
//   arb_state_e           : arbiter FSM states.
package wb_pkg;

  localparam int WB_AW = 32;
  localparam int WB_DW = 32;
  localparam int WB_SW = WB_DW / 8;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/wb_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority encoder.
//   req : request vector, one bit per master.
//   ptr : index that has highest priority this round.
//   gnt : one-hot winner (all zero when nothing requests).
//   idx : binary index of the winner.
//   any : at least one request present.
// Scan order is ptr, ptr+1, ..., NUM_M-1, 0, ..., ptr-1.
module rr_pick #(
  parameter int NUM_M = 2,
  parameter int PW    = 1
) (
  input  logic [NUM_M-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [NUM_M-1:0] gnt,
  output logic [PW-1:0]    idx,
  output logic             any
);

  always_comb begin
    int j;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < NUM_M; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_M) j = j - NUM_M;
      // First hit wins; 'any' latches so later candidates are ignored.
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = PW'(j);
      end
    end
  end

endmodule

// File: rtl/wb_arbiter_rr.sv
// wb_arbiter_rr: round-robin Wishbone B4 classic arbiter, NUM_M masters to
// one slave, with a per-transfer watchdog that turns a missing ack into a
// bus error.
//   wb_clk_i, wb_rst_ni       : clock, asynchronous active-low reset.
//   m_*_i                     : packed master request buses, master i in
//                               slice i of each vector.
//   m_dat_o, m_ack_o, m_err_o : read data (broadcast), per-master ack/err.
//   s_*_o, s_dat_i/ack_i/err_i: single slave port.
//   gnt_o                     : one-hot grant; non-zero exactly in BUSY, so
//                               it doubles as the FSM state view.
// Handshake: a beat is offered while cyc&stb are high and completes in the
// clock where ack (or err) is high; the master holds its signals until then.
// A master owns the bus from grant until it drops cyc.
module wb_arbiter_rr
  import wb_pkg::*;
#(
  parameter int NUM_M     = 2,
  parameter int TO_CYCLES = 255,
  parameter int TO_W      = 8
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_ni,
  input  logic [NUM_M*WB_AW-1:0]   m_adr_i,
  input  logic [NUM_M*WB_DW-1:0]   m_dat_i,
  input  logic [NUM_M*WB_SW-1:0]   m_sel_i,
  input  logic [NUM_M-1:0]         m_we_i,
  input  logic [NUM_M-1:0]         m_cyc_i,
  input  logic [NUM_M-1:0]         m_stb_i,
  input  logic [NUM_M*3-1:0]       m_cti_i,
  input  logic [NUM_M*2-1:0]       m_bte_i,
  output logic [WB_DW-1:0]         m_dat_o,
  output logic [NUM_M-1:0]         m_ack_o,
  output logic [NUM_M-1:0]         m_err_o,
  output logic [WB_AW-1:0]         s_adr_o,
  output logic [WB_DW-1:0]         s_dat_o,
  output logic [WB_SW-1:0]         s_sel_o,
  output logic                     s_we_o,
  output logic                     s_cyc_o,
  output logic                     s_stb_o,
  output logic [2:0]               s_cti_o,
  output logic [1:0]               s_bte_o,
  input  logic [WB_DW-1:0]         s_dat_i,
  input  logic                     s_ack_i,
  input  logic                     s_err_i,
  output logic [NUM_M-1:0]         gnt_o
);

  localparam int PW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

  arb_state_e       state, state_nxt;
  logic [NUM_M-1:0] gnt_q, gnt_nxt;
  logic [PW-1:0]    idx_q, idx_nxt;
  logic [PW-1:0]    ptr_q, ptr_nxt;

  logic [NUM_M-1:0] pick_gnt;
  logic [PW-1:0]    pick_idx;
  logic             pick_any;

  logic             release_c;
  logic             stb_raw;
  logic             timeout;
  logic             ack_pass;
  logic             err_pass;

  rr_pick #(.NUM_M(NUM_M), .PW(PW)) u_pick (
    .req (m_cyc_i),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Granted master has let go of its cycle.
  assign release_c = (state == BUSY) && !(|(m_cyc_i & gnt_q));

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state <= IDLE;
      gnt_q <= '0;
      idx_q <= '0;
      ptr_q <= '0;
    end else begin
      state <= state_nxt;
      gnt_q <= gnt_nxt;
      idx_q <= idx_nxt;
      ptr_q <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt_q;
    idx_nxt   = idx_q;
    ptr_nxt   = ptr_q;
    case (state)
      IDLE: begin
        if (pick_any) begin
          state_nxt = BUSY;
          gnt_nxt   = pick_gnt;
          idx_nxt   = pick_idx;
        end
      end
      BUSY: begin
        if (release_c) begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
          ptr_nxt   = (idx_q == PW'(NUM_M - 1)) ? '0 : idx_q + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  // Slave-side mux. gnt_q is all-zero in IDLE, so every s_* output is 0
  // there; s_cyc_o follows the granted master's cyc and drops with it.
  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_cyc_o = 1'b0;
    s_cti_o = '0;
    s_bte_o = '0;
    stb_raw = 1'b0;
    for (int i = 0; i < NUM_M; i++) begin
      if (gnt_q[i]) begin
        s_adr_o = m_adr_i[i*WB_AW +: WB_AW];
        s_dat_o = m_dat_i[i*WB_DW +: WB_DW];
        s_sel_o = m_sel_i[i*WB_SW +: WB_SW];
        s_we_o  = m_we_i[i];
        s_cyc_o = m_cyc_i[i];
        s_cti_o = m_cti_i[i*3 +: 3];
        s_bte_o = m_bte_i[i*2 +: 2];
        stb_raw = m_stb_i[i] & m_cyc_i[i];
      end
    end
  end

  // The timeout clock withdraws the strobe so the slave cannot complete a
  // beat the master has already been told failed.
  assign s_stb_o  = stb_raw & ~timeout;

  // err beats ack when both arrive; timeout is only raised without ack.
  assign ack_pass = s_ack_i & ~s_err_i;
  assign err_pass = s_err_i | timeout;
  assign m_ack_o  = gnt_q & {NUM_M{ack_pass}};
  assign m_err_o  = gnt_q & {NUM_M{err_pass}};
  assign m_dat_o  = (|gnt_q) ? s_dat_i : '0;
  assign gnt_o    = gnt_q;

  generate
    if (TO_CYCLES > 0) begin : g_wd
      localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYCLES - 1);
      logic [TO_W-1:0] wd_cnt;

      assign timeout = stb_raw && !s_ack_i && (wd_cnt == TO_LAST);

      // Counts strobed clocks still waiting for a response; holds while the
      // master pauses its strobe inside a cycle.
      always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
          wd_cnt <= '0;
        end else if (release_c || s_ack_i || s_err_i || timeout) begin
          wd_cnt <= '0;
        end else if (stb_raw) begin
          wd_cnt <= wd_cnt + 1'b1;
        end
      end
    end else begin : g_no_wd
      assign timeout = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_wb_arbiter_rr.sv
module tb_wb_arbiter_rr;
  import wb_pkg::*;

  localparam int NM = 2;
  localparam int TO = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;

  // ---------------- DUT signals ----------------
  logic [NM*32-1:0] m_adr, m_dat;
  logic [NM*4-1:0]  m_sel;
  logic [NM-1:0]    m_we, m_cyc, m_stb;
  logic [NM*3-1:0]  m_cti;
  logic [NM*2-1:0]  m_bte;
  logic [31:0]      m_dat_o;
  logic [NM-1:0]    m_ack_o, m_err_o, gnt_o;
  logic [31:0]      s_adr_o, s_dat_o;
  logic [3:0]       s_sel_o;
  logic             s_we_o, s_cyc_o, s_stb_o;
  logic [2:0]       s_cti_o;
  logic [1:0]       s_bte_o;
  logic [31:0]      s_dat_i;
  logic             s_ack_i, s_err_i;

  // Slave model: either table-driven ack/err, or an auto slave that acks
  // the clock after it sees a strobe and returns data derived from address.
  logic auto_en = 1'b0;
  logic auto_ack;
  logic man_ack = 1'b0;
  logic man_err = 1'b0;
  localparam logic [31:0] MAN_DAT = 32'hCAFE_F00D;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) auto_ack <= 1'b0;
    else        auto_ack <= s_cyc_o & s_stb_o & ~auto_ack;
  end
  assign s_ack_i = auto_en ? auto_ack : man_ack;
  assign s_err_i = auto_en ? 1'b0 : man_err;
  assign s_dat_i = auto_en ? {4{s_adr_o[7:0] + 8'h31}} : MAN_DAT;

  wb_arbiter_rr #(.NUM_M(NM), .TO_CYCLES(TO), .TO_W(8)) dut (
    .wb_clk_i (clk),     .wb_rst_ni (rst_n),
    .m_adr_i  (m_adr),   .m_dat_i   (m_dat),   .m_sel_i (m_sel),
    .m_we_i   (m_we),    .m_cyc_i   (m_cyc),   .m_stb_i (m_stb),
    .m_cti_i  (m_cti),   .m_bte_i   (m_bte),
    .m_dat_o  (m_dat_o), .m_ack_o   (m_ack_o), .m_err_o (m_err_o),
    .s_adr_o  (s_adr_o), .s_dat_o   (s_dat_o), .s_sel_o (s_sel_o),
    .s_we_o   (s_we_o),  .s_cyc_o   (s_cyc_o), .s_stb_o (s_stb_o),
    .s_cti_o  (s_cti_o), .s_bte_o   (s_bte_o),
    .s_dat_i  (s_dat_i), .s_ack_i   (s_ack_i), .s_err_i (s_err_i),
    .gnt_o    (gnt_o)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    m_cyc   = '0;
    m_stb   = '0;
    m_cti   = '0;
    man_ack = 1'b0;
    man_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] gnt_index(input logic [NM-1:0] g);
    if (g == 2'b01) return 32'd0;
    if (g == 2'b10) return 32'd1;
    return 32'd99;
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]  cyc, stb;
    logic        ack, err;
    logic [1:0]  gnt;
    logic        scyc, sstb;
    logic [31:0] sadr;
    logic [1:0]  mack, merr;
  } vec_t;
  vec_t vq[$];

  task automatic add(input logic [1:0] cyc, input logic [1:0] stb, input logic ack,
                     input logic err, input logic [1:0] gnt, input logic scyc,
                     input logic sstb, input logic [31:0] sadr, input logic [1:0] mack,
                     input logic [1:0] merr);
    vec_t v;
    v.cyc = cyc; v.stb = stb; v.ack = ack; v.err = err; v.gnt = gnt;
    v.scyc = scyc; v.sstb = sstb; v.sadr = sadr; v.mack = mack; v.merr = merr;
    vq.push_back(v);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin : main
    int rem[2];
    int acks[2];
    logic [1:0] drop_now, drop_nxt, prev_g;
    int n, beat;

    m_adr = '0; m_dat = {32'h2222_2222, 32'h1111_1111}; m_sel = 8'hF3;
    m_we  = '0; m_cyc = '0; m_stb = '0; m_cti = '0; m_bte = '0;

    // -------- reset state --------
    do_reset();
    m_adr = {32'h200, 32'h100};
    check("rst gnt",   32'(gnt_o),   0);
    check("rst s_cyc", 32'(s_cyc_o), 0);
    check("rst s_stb", 32'(s_stb_o), 0);
    check("rst s_adr", s_adr_o,      0);
    check("rst s_dat", s_dat_o,      0);
    check("rst m_ack", 32'(m_ack_o), 0);
    check("rst m_err", 32'(m_err_o), 0);
    check("rst m_dat", m_dat_o,      0);

    // -------- single master read, auto slave --------
    auto_en = 1'b1;
    m_adr[31:0] = 32'h10;
    m_cyc = 2'b01; m_stb = 2'b01;
    @(negedge clk);
    check("single s_cyc latency", 32'(s_cyc_o), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("single s_cyc", 32'(s_cyc_o), 1);
    check("single s_adr", s_adr_o, 32'h10);
    check("single s_dat", s_dat_o, 32'h1111_1111);
    check("single no ack yet", 32'(m_ack_o), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("single m_ack", 32'(m_ack_o), 32'b01);
    check("single m_dat", m_dat_o, 32'h4141_4141);
    @(posedge clk); #1;
    m_cyc = 2'b00; m_stb = 2'b00;
    @(negedge clk);
    check("single release s_cyc", 32'(s_cyc_o), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("single idle gnt", 32'(gnt_o), 0);

    // -------- table: contention, watchdog, ack/err priority, idle rules --------
    add(2'b00, 2'b00, 0, 0, 2'b00, 0, 0, 32'h0,   2'b00, 2'b00);
    add(2'b11, 2'b11, 0, 0, 2'b00, 0, 0, 32'h0,   2'b00, 2'b00);
    add(2'b11, 2'b11, 1, 0, 2'b01, 1, 1, 32'h100, 2'b01, 2'b00);
    add(2'b10, 2'b10, 0, 0, 2'b01, 0, 0, 32'h100, 2'b00, 2'b00);
    add(2'b10, 2'b10, 0, 0, 2'b00, 0, 0, 32'h0,   2'b00, 2'b00);
    add(2'b10, 2'b10, 0, 0, 2'b10, 1, 1, 32'h200, 2'b00, 2'b00);
    add(2'b10, 2'b10, 0, 0, 2'b10, 1, 1, 32'h200, 2'b00, 2'b00);
    add(2'b10, 2'b10, 0, 0, 2'b10, 1, 1, 32'h200, 2'b00, 2'b00);
    add(2'b10, 2'b10, 0, 0, 2'b10, 1, 0, 32'h200, 2'b00, 2'b10);
    add(2'b10, 2'b10, 0, 0, 2'b10, 1, 1, 32'h200, 2'b00, 2'b00);
    add(2'b10, 2'b10, 0, 0, 2'b10, 1, 1, 32'h200, 2'b00, 2'b00);
    add(2'b10, 2'b10, 0, 0, 2'b10, 1, 1, 32'h200, 2'b00, 2'b00);
    add(2'b10, 2'b10, 1, 0, 2'b10, 1, 1, 32'h200, 2'b10, 2'b00);
    add(2'b11, 2'b11, 0, 0, 2'b10, 1, 1, 32'h200, 2'b00, 2'b00);
    add(2'b11, 2'b11, 1, 1, 2'b10, 1, 1, 32'h200, 2'b00, 2'b10);
    add(2'b01, 2'b01, 0, 0, 2'b10, 0, 0, 32'h200, 2'b00, 2'b00);
    add(2'b01, 2'b01, 0, 0, 2'b00, 0, 0, 32'h0,   2'b00, 2'b00);
    add(2'b01, 2'b01, 1, 0, 2'b01, 1, 1, 32'h100, 2'b01, 2'b00);
    add(2'b00, 2'b00, 0, 0, 2'b01, 0, 0, 32'h100, 2'b00, 2'b00);
    add(2'b01, 2'b00, 0, 0, 2'b00, 0, 0, 32'h0,   2'b00, 2'b00);
    add(2'b01, 2'b00, 0, 0, 2'b01, 1, 0, 32'h100, 2'b00, 2'b00);
    add(2'b00, 2'b00, 0, 0, 2'b01, 0, 0, 32'h100, 2'b00, 2'b00);
    add(2'b00, 2'b01, 0, 0, 2'b00, 0, 0, 32'h0,   2'b00, 2'b00);
    add(2'b00, 2'b01, 0, 0, 2'b00, 0, 0, 32'h0,   2'b00, 2'b00);

    auto_en = 1'b0;
    do_reset();
    m_adr = {32'h200, 32'h100};
    for (int i = 0; i < vq.size(); i++) begin
      m_cyc = vq[i].cyc; m_stb = vq[i].stb;
      man_ack = vq[i].ack; man_err = vq[i].err;
      @(negedge clk);
      check($sformatf("row%0d gnt", i),   32'(gnt_o),   32'(vq[i].gnt));
      check($sformatf("row%0d s_cyc", i), 32'(s_cyc_o), 32'(vq[i].scyc));
      check($sformatf("row%0d s_stb", i), 32'(s_stb_o), 32'(vq[i].sstb));
      check($sformatf("row%0d s_adr", i), s_adr_o,      vq[i].sadr);
      check($sformatf("row%0d m_ack", i), 32'(m_ack_o), 32'(vq[i].mack));
      check($sformatf("row%0d m_err", i), 32'(m_err_o), 32'(vq[i].merr));
      check($sformatf("row%0d m_dat", i), m_dat_o, (vq[i].gnt != 2'b00) ? MAN_DAT : 32'h0);
      @(posedge clk); #1;
    end
    man_ack = 1'b0; man_err = 1'b0;

    // -------- fairness: 4 single-beat cycles each --------
    do_reset();
    auto_en = 1'b1;
    m_adr = {32'h204, 32'h104};
    exp_q = {32'd0, 32'd1, 32'd0, 32'd1, 32'd0, 32'd1, 32'd0, 32'd1};
    rem[0] = 4; rem[1] = 4; acks[0] = 0; acks[1] = 0;
    drop_now = '0; prev_g = '0; n = 0;
    while ((rem[0] > 0 || rem[1] > 0 || gnt_o != 2'b00) && n < 200) begin
      for (int i = 0; i < NM; i++) begin
        m_cyc[i] = (rem[i] > 0) && !drop_now[i];
        m_stb[i] = (rem[i] > 0) && !drop_now[i];
      end
      @(negedge clk);
      drop_nxt = '0;
      if (gnt_o != 2'b00 && prev_g == 2'b00) begin
        if (exp_q.size() > 0) check("fair grant order", gnt_index(gnt_o), exp_q.pop_front());
        else check("fair extra grant", 32'(gnt_o), 0);
      end
      for (int i = 0; i < NM; i++) begin
        if (m_ack_o[i]) begin
          acks[i]++;
          rem[i]--;
          drop_nxt[i] = 1'b1;
        end
      end
      prev_g = gnt_o; drop_now = drop_nxt; n++;
      @(posedge clk); #1;
    end
    m_cyc = '0; m_stb = '0;
    check("fair within budget", 32'(n < 200), 1);
    check("fair grants left", 32'(exp_q.size()), 0);
    check("fair acks m0", 32'(acks[0]), 4);
    check("fair acks m1", 32'(acks[1]), 4);

    // -------- grant hold across m1's incrementing burst --------
    do_reset();
    auto_en = 1'b1;
    m_adr = {32'h20, 32'h100};
    beat = 0; n = 0;
    while (beat < 3 && n < 50) begin
      m_adr[63:32] = 32'h20 + 32'(beat * 4);
      m_cti[5:3]   = (beat == 2) ? CTI_EOB : CTI_INCR;
      m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
      if (n >= 1) begin m_cyc[0] = 1'b1; m_stb[0] = 1'b1; end
      @(negedge clk);
      if (n >= 1) begin
        check("burst gnt", 32'(gnt_o), 32'b10);
        check("burst s_adr", s_adr_o, 32'h20 + 32'(beat * 4));
        check("burst s_cti", 32'(s_cti_o), 32'((beat == 2) ? CTI_EOB : CTI_INCR));
        check("burst m0 no ack", 32'(m_ack_o[0]), 0);
      end
      if (m_ack_o[1]) beat++;
      n++;
      @(posedge clk); #1;
    end
    check("burst beats", 32'(beat), 3);
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0; m_cti = '0;
    @(negedge clk);
    check("burst release gnt", 32'(gnt_o), 32'b10);
    check("burst release s_cyc", 32'(s_cyc_o), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("burst dead cycle", 32'(gnt_o), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("burst then m0 gnt", 32'(gnt_o), 32'b01);
    check("burst then m0 adr", s_adr_o, 32'h100);
    @(posedge clk); #1;
    m_cyc = '0; m_stb = '0;
    @(posedge clk); #1;

    // -------- reset asserted mid-transfer --------
    do_reset();
    auto_en = 1'b0;
    m_adr = {32'h400, 32'h300};
    m_cyc = 2'b01; m_stb = 2'b01;
    @(posedge clk); #1;
    man_ack = 1'b1;
    @(negedge clk);
    check("pre-reset s_cyc", 32'(s_cyc_o), 1);
    check("pre-reset m_ack", 32'(m_ack_o), 32'b01);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst s_cyc", 32'(s_cyc_o), 0);
    check("async rst s_stb", 32'(s_stb_o), 0);
    check("async rst gnt",   32'(gnt_o),   0);
    check("async rst m_ack", 32'(m_ack_o), 0);
    man_ack = 1'b0;
    m_cyc = 2'b11; m_stb = 2'b11;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("post-reset gnt", 32'(gnt_o), 32'b01);
    check("post-reset s_adr", s_adr_o, 32'h300);
    @(posedge clk); #1;
    m_cyc = '0; m_stb = '0;
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_arbiter_rr.md
Name: wb_arbiter_rr

Overview:
- Round-robin Wishbone B4 classic arbiter: NUM_M bus masters share one slave port, for example the SD-emulation register/data slaves on the sd_emu bus.
- Grant is held for a whole master bus cycle (wb_cyc high), including back-to-back beats.
- A per-transfer watchdog returns a bus error if the slave never acknowledges, so an unresponsive slave cannot lock up the SD emulation fabric.

Parameters:
- NUM_M, 2, number of masters (2..8).
- TO_CYCLES, 255, watchdog limit in clocks of unacknowledged strobe; 0 disables the watchdog.
- TO_W, 8, watchdog counter width; must hold TO_CYCLES.

Ports:
- wb_clk_i  in  1  bus clock.
- wb_rst_ni  in  1  asynchronous active-low reset.
- m_adr_i  in  NUM_M*32  master addresses, master i at bits [32i+31:32i].
- m_dat_i  in  NUM_M*32  master write data.
- m_sel_i  in  NUM_M*4  master byte selects.
- m_we_i  in  NUM_M  master write enables.
- m_cyc_i  in  NUM_M  master cycle requests.
- m_stb_i  in  NUM_M  master strobes.
- m_cti_i  in  NUM_M*3  master cycle type.
- m_bte_i  in  NUM_M*2  master burst type.
- m_dat_o  out  32  read data, broadcast to all masters.
- m_ack_o  out  NUM_M  per-master ack.
- m_err_o  out  NUM_M  per-master error.
- s_adr_o  out  32  slave address.
- s_dat_o  out  32  slave write data.
- s_sel_o  out  4  slave byte selects.
- s_we_o  out  1  slave write enable.
- s_cyc_o  out  1  slave cycle.
- s_stb_o  out  1  slave strobe.
- s_cti_o  out  3  slave cycle type.
- s_bte_o  out  2  slave burst type.
- s_dat_i  in  32  slave read data.
- s_ack_i  in  1  slave ack.
- s_err_i  in  1  slave error.
- gnt_o  out  NUM_M  one-hot current grant (debug/status).

Behaviour:
- Reset (wb_rst_ni low, asynchronous assert, synchronous deassert handled upstream):
  - state=IDLE, gnt_o=0, priority pointer=0, watchdog=0.
  - All s_* outputs 0; m_ack_o=0, m_err_o=0.
- FSM states: IDLE, BUSY.
- IDLE:
  - If any m_cyc_i is high, pick the first requester scanning from pointer upward with wrap (pointer, pointer+1, ..., NUM_M-1, 0, ...).
  - Register gnt_o one-hot and go to BUSY. Arbitration latency is 1 clock: the slave sees the winner's signals the cycle after its cyc is first sampled.
  - No requests: stay in IDLE.
- BUSY:
  - s_* outputs are a combinational mux of the granted master's inputs.
  - Slave ack/err are routed combinationally to the granted master only; other masters' ack/err stay 0.
  - m_dat_o = s_dat_i whenever granted; 0 in IDLE.
- Release: granted m_cyc_i sampled low in BUSY ->
  - gnt_o=0, pointer = granted index+1 (mod NUM_M), state=IDLE.
  - s_cyc_o drops combinationally in that same cycle, since it follows the master.
  - Minimum one idle cycle between grants, so two masters alternate with 1 dead cycle.
- Watchdog (TO_CYCLES>0):
  - Counts each BUSY clock with s_stb_o high and s_ack_i=0 and s_err_i=0.
  - Clears on ack, err, or release.
  - When count==TO_CYCLES-1 and no ack that cycle: assert m_err_o[granted] for exactly 1 clock, force s_stb_o low that clock, clear the counter.
  - The master keeps its grant; it decides whether to retry or drop cyc.
- Simultaneous events:
  - s_ack_i and timeout in the same cycle: ack wins, no err.
  - s_ack_i and s_err_i both high: err passed, ack suppressed.
- Masters with cyc low are never granted, even when the pointer rests on them.
- Misuse: gnt_o is never multi-hot. Master stb without cyc is ignored.
- Reset asserted mid-transfer: everything returns to reset values immediately. The slave sees cyc drop asynchronously; no ack is delivered.

Decomposition:
- Shared package/include wb_pkg: Wishbone CTI/BTE localparams and a WB_DW=32 / WB_AW=32 width constant.
- One sub-module, rr_pick:
  - Combinational round-robin priority encoder.
  - Inputs: req[NUM_M], ptr.
  - Outputs: one-hot gnt, gnt index, any.
- The FSM, mux and watchdog stay in wb_arbiter_rr.

Test Plan:
- Single master: m0 reads addr 0x10, wb_a-style slave acks after 1 clock -> s_cyc_o rises 1 clock after m_cyc_i[0]; m_dat_o=0x41414141; m_ack_o=2'b01; m_ack_o[1] stays 0.
- Contention: m0 and m1 raise cyc in the same cycle with pointer=0 -> gnt_o=01. After m0 drops cyc: 1 idle cycle, then gnt_o=10, pointer=0 after m1 releases.
- Fairness: m0 and m1 both issue 4 back-to-back single-beat cycles -> grant order 0,1,0,1,0,1,0,1; m_ack_o counts 4 and 4.
- Grant hold: m1 does a 3-beat incrementing burst (cti=010, 111 last) while m0 requests -> m0 is not granted until m1's cyc drops; s_adr_o follows m1 for all beats.
- Watchdog: TO_CYCLES=4, slave never acks -> m_err_o[granted]=1 on the 4th strobed clock, s_stb_o low that clock, counter restarts. Ack arriving exactly on the 4th clock -> ack, no err.
- Reset mid-burst: wb_rst_ni low during m0's BUSY -> s_cyc_o, gnt_o and m_ack_o are 0 within the same clock edge-free window. After release, pointer=0 and the first requester is granted normally.
